// File: rtl/square_motion_ctrl.sv
// rtl/square_motion_ctrl.sv - per-frame bouncing-square position scheduler with double-buffered coordinates
module square_motion_ctrl #(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int SIZE   = 200,
    parameter int X_INIT = 220,
    parameter int Y_INIT = 140
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame,
    input  logic             i_run,
    input  logic [2:0]       i_speed,
    input  logic             i_recenter,
    output logic [CORDW-1:0] o_x0,
    output logic [CORDW-1:0] o_y0,
    output logic [CORDW-1:0] o_x1,
    output logic [CORDW-1:0] o_y1,
    output logic             o_update,
    output logic             o_bounce_x,
    output logic             o_bounce_y,
    output logic             o_missed
);

    localparam logic [CORDW:0]   MAXX    = (CORDW+1)'(H_RES - SIZE);
    localparam logic [CORDW:0]   MAXY    = (CORDW+1)'(V_RES - SIZE);
    localparam logic [CORDW-1:0] X0_INIT = CORDW'(X_INIT);
    localparam logic [CORDW-1:0] Y0_INIT = CORDW'(Y_INIT);
    localparam logic [CORDW-1:0] X1_INIT = CORDW'(X_INIT + SIZE - 1);
    localparam logic [CORDW-1:0] Y1_INIT = CORDW'(Y_INIT + SIZE - 1);
    localparam logic [CORDW-1:0] SZ_M1   = CORDW'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_MOVE_X = 2'd1,
        ST_MOVE_Y = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_spd;
    logic [CORDW-1:0] r_sx;
    logic [CORDW-1:0] r_sy;
    logic             r_dir_x;
    logic             r_dir_y;
    logic             r_pend_bx;
    logic             r_pend_by;
    logic             r_recenter;
    logic [CORDW-1:0] r_x0;
    logic [CORDW-1:0] r_y0;
    logic [CORDW-1:0] r_x1;
    logic [CORDW-1:0] r_y1;
    logic             r_update;
    logic             r_bounce_x;
    logic             r_bounce_y;
    logic             r_missed;

    // One extra bit of headroom so x + spd cannot wrap past MAX
    logic [CORDW:0] w_spd_ext;
    logic [CORDW:0] w_x_ext;
    logic [CORDW:0] w_y_ext;
    logic [CORDW:0] w_x_inc;
    logic [CORDW:0] w_y_inc;
    logic [CORDW:0] w_x_dec;
    logic [CORDW:0] w_y_dec;
    logic           w_x_hit_hi;
    logic           w_x_hit_lo;
    logic           w_y_hit_hi;
    logic           w_y_hit_lo;
    logic           w_do_recenter;

    assign w_spd_ext  = {{(CORDW-2){1'b0}}, r_spd};
    assign w_x_ext    = {1'b0, r_sx};
    assign w_y_ext    = {1'b0, r_sy};
    assign w_x_inc    = w_x_ext + w_spd_ext;
    assign w_y_inc    = w_y_ext + w_spd_ext;
    assign w_x_dec    = w_x_ext - w_spd_ext;
    assign w_y_dec    = w_y_ext - w_spd_ext;
    assign w_x_hit_hi = (w_x_inc >= MAXX);
    assign w_y_hit_hi = (w_y_inc >= MAXY);
    assign w_x_hit_lo = (w_x_ext <= w_spd_ext);
    assign w_y_hit_lo = (w_y_ext <= w_spd_ext);
    assign w_do_recenter = r_recenter | i_recenter;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_WAIT;
            r_spd      <= 3'd0;
            r_sx       <= X0_INIT;
            r_sy       <= Y0_INIT;
            r_dir_x    <= 1'b0;
            r_dir_y    <= 1'b0;
            r_pend_bx  <= 1'b0;
            r_pend_by  <= 1'b0;
            r_recenter <= 1'b0;
            r_x0       <= X0_INIT;
            r_y0       <= Y0_INIT;
            r_x1       <= X1_INIT;
            r_y1       <= Y1_INIT;
            r_update   <= 1'b0;
            r_bounce_x <= 1'b0;
            r_bounce_y <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            r_update   <= 1'b0;
            r_bounce_x <= 1'b0;
            r_bounce_y <= 1'b0;
            if (i_recenter) begin
                r_recenter <= 1'b1;
            end
            if (i_frame && (r_state != ST_WAIT)) begin
                r_missed <= 1'b1;
            end
            case (r_state)
                ST_WAIT: begin
                    if (i_frame && i_run) begin
                        r_spd     <= i_speed;
                        r_pend_bx <= 1'b0;
                        r_pend_by <= 1'b0;
                        r_state   <= ST_MOVE_X;
                    end
                end
                ST_MOVE_X: begin
                    if (!r_dir_x) begin
                        if (w_x_hit_hi) begin
                            r_sx      <= MAXX[CORDW-1:0];
                            r_dir_x   <= 1'b1;
                            r_pend_bx <= 1'b1;
                        end else begin
                            r_sx <= w_x_inc[CORDW-1:0];
                        end
                    end else begin
                        if (w_x_hit_lo) begin
                            r_sx      <= '0;
                            r_dir_x   <= 1'b0;
                            r_pend_bx <= 1'b1;
                        end else begin
                            r_sx <= w_x_dec[CORDW-1:0];
                        end
                    end
                    r_state <= ST_MOVE_Y;
                end
                ST_MOVE_Y: begin
                    if (!r_dir_y) begin
                        if (w_y_hit_hi) begin
                            r_sy      <= MAXY[CORDW-1:0];
                            r_dir_y   <= 1'b1;
                            r_pend_by <= 1'b1;
                        end else begin
                            r_sy <= w_y_inc[CORDW-1:0];
                        end
                    end else begin
                        if (w_y_hit_lo) begin
                            r_sy      <= '0;
                            r_dir_y   <= 1'b0;
                            r_pend_by <= 1'b1;
                        end else begin
                            r_sy <= w_y_dec[CORDW-1:0];
                        end
                    end
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // Recentre overrides whatever motion this pass produced
                    if (w_do_recenter) begin
                        r_sx       <= X0_INIT;
                        r_sy       <= Y0_INIT;
                        r_x0       <= X0_INIT;
                        r_y0       <= Y0_INIT;
                        r_x1       <= X1_INIT;
                        r_y1       <= Y1_INIT;
                        r_dir_x    <= 1'b0;
                        r_dir_y    <= 1'b0;
                        r_recenter <= 1'b0;
                    end else begin
                        r_x0       <= r_sx;
                        r_y0       <= r_sy;
                        r_x1       <= r_sx + SZ_M1;
                        r_y1       <= r_sy + SZ_M1;
                        r_bounce_x <= r_pend_bx;
                        r_bounce_y <= r_pend_by;
                    end
                    r_update <= 1'b1;
                    r_state  <= ST_WAIT;
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    assign o_x0       = r_x0;
    assign o_y0       = r_y0;
    assign o_x1       = r_x1;
    assign o_y1       = r_y1;
    assign o_update   = r_update;
    assign o_bounce_x = r_bounce_x;
    assign o_bounce_y = r_bounce_y;
    assign o_missed   = r_missed;

endmodule
